// File: rtl/systolic_feeder.sv
// Edge feeder for an N x N systolic MAC array: skews A/B slices diagonally across lanes
// and closes each job with a per-lane finished pulse followed by zeros.
module systolic_feeder #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_last,
    input  logic [N*DW-1:0] a_vec,
    input  logic [N*DW-1:0] b_vec,
    output logic [N*DW-1:0] a_out,
    output logic [N*DW-1:0] b_out,
    output logic [N-1:0]    a_fin,
    output logic [N-1:0]    b_fin,
    output logic            done,
    output logic [15:0]     beat_cnt
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StFlush
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_flush_cnt;
    logic [15:0]     r_beat_cnt;
    logic            r_last_pend;
    logic [N*DW-1:0] r_s0_a;
    logic [N*DW-1:0] r_s0_b;
    logic            r_s0_fin;
    logic            w_accept;

    // rst gates in_ready directly so no slice is offered while reset is held
    assign in_ready = rst && (r_state != StFlush);
    assign w_accept = in_valid && in_ready;
    assign beat_cnt = r_beat_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= StIdle;
            r_flush_cnt <= '0;
            r_beat_cnt  <= '0;
        end else begin
            unique case (r_state)
                StIdle, StStream: begin
                    if (w_accept) begin
                        r_beat_cnt  <= (r_state == StIdle) ? 16'd1 : r_beat_cnt + 16'd1;
                        r_flush_cnt <= '0;
                        r_state     <= in_last ? StFlush : StStream;
                    end
                end
                StFlush: begin
                    if (r_flush_cnt == CW'(N - 1)) begin
                        r_state <= StIdle;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + CW'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Stage 0: accepted data for one slot, then a fin slot one cycle after the last data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s0_a      <= '0;
            r_s0_b      <= '0;
            r_s0_fin    <= 1'b0;
            r_last_pend <= 1'b0;
        end else begin
            r_s0_a      <= w_accept ? a_vec : '0;
            r_s0_b      <= w_accept ? b_vec : '0;
            r_last_pend <= w_accept && in_last;
            r_s0_fin    <= r_last_pend;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        if (i == 0) begin : g_direct
            assign a_out[DW-1:0] = r_s0_a[DW-1:0];
            assign b_out[DW-1:0] = r_s0_b[DW-1:0];
            assign a_fin[0]      = r_s0_fin;
            assign b_fin[0]      = r_s0_fin;
        end else begin : g_delay
            logic [DW-1:0] r_a_dly   [i];
            logic [DW-1:0] r_b_dly   [i];
            logic          r_fin_dly [i];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < i; k++) begin
                        r_a_dly[k]   <= '0;
                        r_b_dly[k]   <= '0;
                        r_fin_dly[k] <= 1'b0;
                    end
                end else begin
                    r_a_dly[0]   <= r_s0_a[i*DW +: DW];
                    r_b_dly[0]   <= r_s0_b[i*DW +: DW];
                    r_fin_dly[0] <= r_s0_fin;
                    for (int k = 1; k < i; k++) begin
                        r_a_dly[k]   <= r_a_dly[k-1];
                        r_b_dly[k]   <= r_b_dly[k-1];
                        r_fin_dly[k] <= r_fin_dly[k-1];
                    end
                end
            end

            assign a_out[i*DW +: DW] = r_a_dly[i-1];
            assign b_out[i*DW +: DW] = r_b_dly[i-1];
            assign a_fin[i]          = r_fin_dly[i-1];
            assign b_fin[i]          = r_fin_dly[i-1];
        end
    end

    assign done = a_fin[N-1];

endmodule
